result_word_fifo: RTL
=====================

Name: result_word_fifo

Overview:
- Output staging stage of vip_core. Sits directly upstream of the output image writer.
- Accepts a byte stream of classification/feature results from the compute core over a valid/ready handshake.
- Packs PACK = DWIDTH/IN_WIDTH values per word, little-endian, and buffers the words in a synchronous FIFO.
- The FIFO is drained through an rdreq/data/empty interface with 1-cycle read latency. It also reports the word count of each completed frame.

Parameters:
- IN_WIDTH, 8, width of one input value.
- DWIDTH, 32, width of one packed FIFO word. Must be an integer multiple of IN_WIDTH.
- DEPTH, 16, FIFO depth in words. Must be a power of 2 and ≥ 2.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input value present.
- in_data  in  IN_WIDTH  input value.
- in_last  in  1  qualifies the final value of a frame.
- in_ready  out  1  block can accept the input value.
- fifo_rdreq  in  1  consumer read request.
- fifo_data  out  DWIDTH  read data, valid the cycle after an accepted rdreq.
- fifo_empty  out  1  FIFO holds no words.
- fifo_full  out  1  FIFO holds DEPTH words.
- num_data  out  32  word count of the last completed frame.
- frame_done  out  1  one-cycle pulse when a frame's final word is pushed.

Behaviour:
- Reset (synchronous, active-high) clears all state. Output values after reset:
  - in_ready = 1
  - fifo_data = 0
  - fifo_empty = 1
  - fifo_full = 0
  - num_data = 0
  - frame_done = 0
  - Lane counter, pointers, occupancy count and frame word counter = 0; any partial word is discarded.
- Accept: `acc = in_valid && in_ready`.
- `in_ready = !fifo_full`. It is derived from registers only; there is no combinational path from fifo_rdreq.
- Packing:
  - A lane counter runs 0..PACK-1. An accepted value is written to `pack_reg[lane*IN_WIDTH +: IN_WIDTH]`.
  - The word completes when `acc && (lane == PACK-1 || in_last)`.
  - The pushed word is the current in_data merged with the earlier lanes. Lanes above the current lane are zero.
  - On completion the lane counter returns to 0 and pack_reg is cleared.
- Push happens on the completing edge; the word is visible to reads from the next cycle.
- Pop:
  - `pop = fifo_rdreq && !fifo_empty`.
  - On pop: `fifo_data <= mem[rd_ptr]` and rd_ptr increments. Latency is exactly 1 cycle.
  - A read request while empty is ignored: no pointer change, fifo_data holds its last value, no error. The consumer registers rdreq from a stale empty and overreads by one cycle; this is legal.
- Occupancy count:
  - Push only: +1. Pop only: −1. Push and pop together: unchanged.
  - Pointers wrap modulo DEPTH.
  - `fifo_empty = (count == 0)`. `fifo_full = (count == DEPTH)`. Both come from registered count.
- Simultaneous push and pop at count = 1: legal. The pop returns the old entry and count stays 1.
- At count = DEPTH, a pop that cycle still keeps in_ready = 0 for that cycle (conservative). Overflow cannot occur.
- Frame accounting:
  - frame_words counts pushes. On the push that carries in_last: `num_data <= frame_words + 1`, frame_done = 1 for one cycle, frame_words <= 0.
  - num_data holds until the next frame's last push.
  - Consumers that write a header read num_data after frame_done.
- in_last on lane 0 produces a word with only lane 0 populated.
- Reset mid-frame or mid-drain: everything returns to the reset values; FIFO contents are lost.

Decomposition:
- Package vip_out_pkg:
  - IN_WIDTH and DWIDTH defaults.
  - `PACK = DWIDTH/IN_WIDTH`.
  - Address width function clog2(DEPTH).
- Sub-module sync_word_fifo (DWIDTH, DEPTH): memory, pointers, count, registered read data, empty/full.
- Packer logic and frame accounting stay in the top.

Test Plan:
- Frame of 8 values, in_data 0x01..0x08 (in_last on 0x08), rdreq held high → reads 0x04030201 then 0x08070605; num_data = 2; frame_done pulses once with the second push.
- Frame of 5 values 0xA0..0xA4 (in_last on 0xA4) → words 0xA3A2A1A0, then 0x000000A4; num_data = 2.
- rdreq held low, continuous input of 16 words' worth of values (DEPTH = 16) → fifo_full = 1 and in_ready = 0 after the 16th push; further in_valid is not accepted. Then a single rdreq → fifo_full drops one cycle after the pop.
- rdreq asserted for 3 cycles with 1 word stored → one valid read; 2 ignored reads; fifo_data holds its value; fifo_empty = 1; pointers stay consistent, proven by a subsequent push/pop returning correct data.
- Push and pop on the same cycle at count = 1 over 20 cycles → count stays 1; read data sequence equals write sequence; no loss.
- reset asserted mid-frame after 3 values and 2 stored words → next cycle: fifo_empty = 1, num_data = 0, in_ready = 1. A fresh 4-value frame then yields exactly one word with correct lane order.

Source files
------------

// File: rtl/vip_out_pkg.sv
// Shared sizing for the vip_core output staging path.
package vip_out_pkg;

  localparam int unsigned IN_WIDTH_DEF = 8;
  localparam int unsigned DWIDTH_DEF   = 32;
  localparam int unsigned PACK_DEF     = DWIDTH_DEF / IN_WIDTH_DEF;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous word FIFO with registered read data and 1-cycle read latency.
module sync_word_fifo
  import vip_out_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rdreq,
  output logic [DWIDTH-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [DWIDTH-1:0] rd_data_q;
  logic              wr_en;
  logic              pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign wr_en   = push && !full;
  assign pop     = rdreq && !empty;
  assign rd_data = rd_data_q;

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_data_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/result_word_fifo.sv
// Packs the result byte stream into little-endian words, buffers them and
// reports the word count of each completed frame.
module result_word_fifo
  import vip_out_pkg::*;
#(
  parameter int unsigned IN_WIDTH = IN_WIDTH_DEF,
  parameter int unsigned DWIDTH   = DWIDTH_DEF,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                fifo_rdreq,
  output logic [DWIDTH-1:0]   fifo_data,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic [31:0]         num_data,
  output logic                frame_done
);

  localparam int unsigned PACK  = DWIDTH / IN_WIDTH;
  localparam int unsigned LaneW = (PACK > 1) ? clog2(PACK) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(PACK - 1);

  logic [LaneW-1:0]  lane_q, lane_d;
  logic [DWIDTH-1:0] pack_q, pack_d;
  logic [DWIDTH-1:0] push_word;
  logic [31:0]       frame_words_q;
  logic [31:0]       num_data_q;
  logic              frame_done_q;
  logic              acc;
  logic              push;

  // Registered-only ready: a same-cycle pop at full does not reopen the input.
  assign in_ready = !fifo_full;
  assign acc      = in_valid && in_ready;
  assign push     = acc && ((lane_q == LastLane) || in_last);

  always_comb begin
    push_word = pack_q;
    push_word[int'(lane_q)*IN_WIDTH +: IN_WIDTH] = in_data;
  end

  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    if (push) begin
      lane_d = '0;
      pack_d = '0;
    end else if (acc) begin
      lane_d = lane_q + LaneW'(1);
      pack_d = push_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q        <= '0;
      pack_q        <= '0;
      frame_words_q <= '0;
      num_data_q    <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      frame_done_q <= push && in_last;
      if (push) begin
        if (in_last) begin
          num_data_q    <= frame_words_q + 32'd1;
          frame_words_q <= '0;
        end else begin
          frame_words_q <= frame_words_q + 32'd1;
        end
      end
    end
  end

  assign num_data   = num_data_q;
  assign frame_done = frame_done_q;

  sync_word_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (push_word),
    .rdreq   (fifo_rdreq),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule
